clock_divider_multi: RTL and testbench
======================================

Name: clock_divider_multi

Overview:
- Parametrised multi-channel successor to the single-output clock divider.
- Each of NUM_CH channels has a runtime-programmable divide value, an enable, and a mode: 50% square wave (toggle) or single-cycle tick pulse.
- New divide values are loaded glitch-free on the channel's next wrap. A global sync clear phase-aligns all channels.
- Sits between the board clock and slow peripherals (display mux, debouncers, UART baud ticks).

Parameters:
- NUM_CH, 4, number of independent divider channels (1..16).
- CNT_WIDTH, 17, width of each channel counter and divide value; must hold DEFAULT_DIV.
- DEFAULT_DIV, 100000, divide value loaded into every channel at reset (rising edges per half-period or per tick).

Ports:
- clk_in  input  1  system clock.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- en  input  NUM_CH  per-channel enable.
- mode  input  NUM_CH  per-channel mode: 0 = toggle (square wave), 1 = pulse (tick only).
- div_val  input  NUM_CH*CNT_WIDTH  flattened divide values; channel i uses bits [i*CNT_WIDTH +: CNT_WIDTH].
- load  input  NUM_CH  one-cycle strobe: capture div_val of channel i.
- sync_clr  input  1  one-cycle strobe: restart all channels in phase.
- clk_out  output  NUM_CH  divided clock per channel (fabric signal, not a clock net).
- tick  output  NUM_CH  one-cycle pulse per channel at each wrap.
- load_err  output  NUM_CH  one-cycle pulse: load rejected because div_val was 0.

Behaviour:
- Reset (reset=0, async), all channels:
  - counter=0, lim=DEFAULT_DIV-1, pend_valid=0.
  - clk_out=0, tick=0, load_err=0.
- Per-channel registers: counter[CNT_WIDTH], lim[CNT_WIDTH], pend[CNT_WIDTH], pend_valid.
- Enabled channel, each clk_in edge:
  - counter==lim (wrap): counter<=0, tick<=1 for one cycle. In mode 0, clk_out<=~clk_out.
  - otherwise: counter<=counter+1, tick<=0, clk_out held.
- Periods:
  - mode 0: clk_out period 2*(lim+1) cycles, 50% duty; tick rises every lim+1 cycles.
  - mode 1: clk_out forced 0; tick period lim+1.
- Latency: tick and clk_out are registered; they change on the edge where counter==lim is sampled.
- Load handling:
  - load[i] with div_val!=0: pend<=div_val-1, pend_valid<=1.
  - At the next wrap: lim<=pend, pend_valid<=0. Running periods are never truncated.
  - load coincident with a wrap: the new value is applied at that wrap directly (lim<=div_val-1).
  - A second load before the wrap overwrites pend (last wins).
  - load[i] with div_val==0: ignored, load_err[i]=1 for one cycle, pend unchanged.
- Disable (en[i]=0):
  - Next edge: counter<=0, clk_out<=0, tick<=0.
  - A valid pend is applied immediately; loads while disabled apply immediately.
  - Re-enable starts from counter 0, so the first tick occurs lim+1 cycles later.
- sync_clr: all channels counter<=0, clk_out<=0, tick<=0, pending values applied. It has priority over wrap and load in the same cycle; that cycle's load is discarded.
- Mode change mid-period: takes effect on the next edge. Switching to 1 forces clk_out=0. Switching to 0 starts low, counter undisturbed.
- lim=0 (div_val=1): mode 0 toggles every cycle (clk_in/2); mode 1 holds tick high continuously.
- reset asserted mid-operation: immediate return to reset values regardless of clk_in.

Decomposition:
- Package clock_divider_pkg: mode enum (MODE_TOGGLE=0, MODE_PULSE=1) and a helper function to slice a channel's div_val.
- Sub-module clock_divider_ch: one channel with counter, lim, pend, mode and outputs.
- Top: generate loop over NUM_CH plus sync_clr fan-out.

Test Plan:
- Reset release, DEFAULT_DIV=4, en=1, mode=0 -> clk_out[i] toggles every 4 cycles (period 8), tick every 4 cycles; all channels in phase.
- Ch0 mode=1, load div_val=3 mid-period at counter=1 of lim=3 -> current period completes, then tick every 3 cycles, clk_out[0] stays 0.
- load with div_val=0 on ch1 -> load_err[1]=1 for one cycle; ch1 period unchanged.
- Ch2 div 5, ch3 div 7 running; pulse sync_clr -> both counters 0, clk_out 0; first ticks 5 and 7 cycles later.
- en[0] low for 10 cycles with load div_val=2 during disable -> clk_out/tick 0 throughout; after re-enable tick every 2 cycles.
- Assert reset mid-period asynchronously (between edges) -> outputs 0 immediately; divide values return to DEFAULT_DIV.

Source files
------------

// File: rtl/clock_divider_pkg.sv
// clock_divider_pkg: shared mode type and div_val slicing for the multi-channel divider
package clock_divider_pkg;
   localparam int MAX_W = 32;
   localparam int MAX_FLAT = 16 * MAX_W;
   typedef enum logic {MODE_TOGGLE = 1'b0, MODE_PULSE = 1'b1} mode_e;
   // Returns the w-bit field of channel ch from a flattened div_val bus.
   function automatic logic [MAX_W-1:0] div_slice(input logic [MAX_FLAT-1:0] flat, input int ch, input int w);
      return MAX_W'(flat >> (ch * w)) & ((MAX_W'(1) << w) - MAX_W'(1));
   endfunction
endpackage

// File: rtl/clock_divider_ch.sv
// clock_divider_ch: one divider channel; new divide values take effect only at a wrap
module clock_divider_ch
   import clock_divider_pkg::*;
#(
   parameter int CNT_WIDTH = 17,
   parameter int DEFAULT_DIV = 100000
) (
   input  logic                 clk_in,
   input  logic                 reset,
   input  logic                 en,
   input  mode_e                mode,
   input  logic [CNT_WIDTH-1:0] div_val,
   input  logic                 load,
   input  logic                 sync_clr,
   output logic                 clk_out,
   output logic                 tick,
   output logic                 load_err
);
   localparam logic [CNT_WIDTH-1:0] ONE = 1;
   logic [CNT_WIDTH-1:0] counter, lim, pend, div_lim, lim_next, pend_lim;
   logic pend_valid, ld_ok, wrap, toggle;
   assign ld_ok = load && (div_val != '0);
   assign div_lim = div_val - ONE;
   assign wrap = counter == lim;
   assign toggle = mode == MODE_TOGGLE;
   assign pend_lim = pend_valid ? pend : lim;
   // sync_clr applies only the pending value; its cycle's load is dropped
   assign lim_next = sync_clr ? pend_lim : (!en || wrap) ? (ld_ok ? div_lim : pend_lim) : lim;
   always_ff @(posedge clk_in or negedge reset)
      if (!reset) begin
         counter <= '0;
         lim <= CNT_WIDTH'(DEFAULT_DIV - 1);
         pend <= '0;
         pend_valid <= 1'b0;
         clk_out <= 1'b0;
         tick <= 1'b0;
         load_err <= 1'b0;
      end else begin
         lim <= lim_next;
         load_err <= load && (div_val == '0);
         if (sync_clr || !en) begin
            counter <= '0;
            clk_out <= 1'b0;
            tick <= 1'b0;
            pend_valid <= 1'b0;
         end else if (wrap) begin
            counter <= '0;
            tick <= 1'b1;
            clk_out <= toggle && !clk_out;
            pend_valid <= 1'b0;
         end else begin
            counter <= counter + ONE;
            tick <= 1'b0;
            clk_out <= toggle && clk_out;
            if (ld_ok) begin
               pend <= div_lim;
               pend_valid <= 1'b1;
            end
         end
      end
endmodule

// File: rtl/clock_divider_multi.sv
// clock_divider_multi: NUM_CH independent programmable dividers with a shared phase-align clear
module clock_divider_multi
   import clock_divider_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int CNT_WIDTH = 17,
   parameter int DEFAULT_DIV = 100000
) (
   input  logic                        clk_in,
   input  logic                        reset,
   input  logic [NUM_CH-1:0]           en,
   input  logic [NUM_CH-1:0]           mode,
   input  logic [NUM_CH*CNT_WIDTH-1:0] div_val,
   input  logic [NUM_CH-1:0]           load,
   input  logic                        sync_clr,
   output logic [NUM_CH-1:0]           clk_out,
   output logic [NUM_CH-1:0]           tick,
   output logic [NUM_CH-1:0]           load_err
);
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      clock_divider_ch #(.CNT_WIDTH(CNT_WIDTH), .DEFAULT_DIV(DEFAULT_DIV)) u_ch (
         .clk_in(clk_in),
         .reset(reset),
         .en(en[i]),
         .mode(mode_e'(mode[i])),
         .div_val(CNT_WIDTH'(div_slice(MAX_FLAT'(div_val), i, CNT_WIDTH))),
         .load(load[i]),
         .sync_clr(sync_clr),
         .clk_out(clk_out[i]),
         .tick(tick[i]),
         .load_err(load_err[i])
      );
   end
endmodule

// File: tb/tb_clock_divider_multi.sv
// tb_clock_divider_multi: directed checks of the multi-channel divider with DEFAULT_DIV=4
module tb_clock_divider_multi;
   localparam int NC = 4;
   localparam int W = 17;
   logic clk_in = 1'b0;
   logic reset;
   logic [NC-1:0] en, mode, load, clk_out, tick, load_err;
   logic [NC*W-1:0] div_val;
   logic sync_clr;
   int n_cmp = 0;
   int n_bad = 0;

   clock_divider_multi #(.NUM_CH(NC), .CNT_WIDTH(W), .DEFAULT_DIV(4)) dut (
      .clk_in(clk_in), .reset(reset), .en(en), .mode(mode), .div_val(div_val),
      .load(load), .sync_clr(sync_clr), .clk_out(clk_out), .tick(tick), .load_err(load_err)
   );

   always #5 clk_in = ~clk_in;

   task automatic test_reset;
      reset = 1'b0; en = '0; mode = '0; load = '0; sync_clr = 1'b0; div_val = '0;
      repeat (3) @(negedge clk_in);
      n_cmp++;
      if ({clk_out, tick, load_err} !== 12'h000) begin
         n_bad++;
         $display("FAIL reset_outputs: got %h want 000", {clk_out, tick, load_err});
      end
      en = '1;
      reset = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk_in);
         n_cmp++;
         if (tick !== ((k % 4 == 0) ? 4'hF : 4'h0)) begin
            n_bad++;
            $display("FAIL default_tick k=%0d: got %h want %h", k, tick, (k % 4 == 0) ? 4'hF : 4'h0);
         end
         n_cmp++;
         if (clk_out !== (((k / 4) % 2 == 1) ? 4'hF : 4'h0)) begin
            n_bad++;
            $display("FAIL default_clk k=%0d: got %h want %h", k, clk_out, ((k / 4) % 2 == 1) ? 4'hF : 4'h0);
         end
      end
   endtask

   task automatic test_pulse_load;
      mode[0] = 1'b1;
      @(negedge clk_in);
      load[0] = 1'b1;
      div_val[0 +: W] = 17'd3;
      for (int j = 1; j <= 12; j++) begin
         @(negedge clk_in);
         load[0] = 1'b0;
         n_cmp++;
         if (tick[0] !== (j % 3 == 0) || clk_out[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL pulse_ch0 j=%0d: got tick=%b clk=%b want tick=%b clk=0", j, tick[0], clk_out[0], j % 3 == 0);
         end
         n_cmp++;
         if (tick[1] !== (j % 4 == 3)) begin
            n_bad++;
            $display("FAIL pulse_ch1_ref j=%0d: got %b want %b", j, tick[1], j % 4 == 3);
         end
      end
   endtask

   task automatic test_load_err;
      load[1] = 1'b1;
      div_val[W +: W] = 17'd0;
      @(negedge clk_in);
      load[1] = 1'b0;
      n_cmp++;
      if (load_err !== 4'b0010) begin
         n_bad++;
         $display("FAIL load_err_pulse: got %b want 0010", load_err);
      end
      @(negedge clk_in);
      n_cmp++;
      if (load_err !== 4'b0000) begin
         n_bad++;
         $display("FAIL load_err_clear: got %b want 0000", load_err);
      end
      for (int m = 32; m <= 40; m++) begin
         @(negedge clk_in);
         n_cmp++;
         if (tick[1] !== (m % 4 == 0)) begin
            n_bad++;
            $display("FAIL load_err_period m=%0d: got %b want %b", m, tick[1], m % 4 == 0);
         end
      end
   endtask

   task automatic test_sync_clr;
      load[3:2] = 2'b11;
      div_val[2*W +: W] = 17'd5;
      div_val[3*W +: W] = 17'd7;
      @(negedge clk_in);
      load = '0;
      repeat (5) @(negedge clk_in);
      sync_clr = 1'b1;
      @(negedge clk_in);
      sync_clr = 1'b0;
      n_cmp++;
      if (clk_out !== 4'h0 || tick !== 4'h0) begin
         n_bad++;
         $display("FAIL sync_clr_outputs: got clk=%h tick=%h want 0 0", clk_out, tick);
      end
      for (int j = 1; j <= 14; j++) begin
         @(negedge clk_in);
         n_cmp++;
         if (tick !== {j % 7 == 0, j % 5 == 0, j % 4 == 0, j % 3 == 0}) begin
            n_bad++;
            $display("FAIL sync_tick j=%0d: got %b want %b", j, tick, {j % 7 == 0, j % 5 == 0, j % 4 == 0, j % 3 == 0});
         end
         n_cmp++;
         if (clk_out[3:2] !== {(j / 7) % 2 == 1, (j / 5) % 2 == 1}) begin
            n_bad++;
            $display("FAIL sync_clk j=%0d: got %b want %b", j, clk_out[3:2], {(j / 7) % 2 == 1, (j / 5) % 2 == 1});
         end
      end
   endtask

   task automatic test_disable;
      en[0] = 1'b0;
      mode[0] = 1'b0;
      for (int d = 1; d <= 10; d++) begin
         @(negedge clk_in);
         load[0] = (d == 3);
         if (d == 3) div_val[0 +: W] = 17'd2;
         n_cmp++;
         if (tick[0] !== 1'b0 || clk_out[0] !== 1'b0 || load_err[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL disabled d=%0d: got tick=%b clk=%b err=%b want 0 0 0", d, tick[0], clk_out[0], load_err[0]);
         end
      end
      load = '0;
      en[0] = 1'b1;
      for (int r = 1; r <= 10; r++) begin
         @(negedge clk_in);
         n_cmp++;
         if (tick[0] !== (r % 2 == 0) || clk_out[0] !== ((r / 2) % 2 == 1)) begin
            n_bad++;
            $display("FAIL reenable r=%0d: got tick=%b clk=%b want tick=%b clk=%b", r, tick[0], clk_out[0], r % 2 == 0, (r / 2) % 2 == 1);
         end
      end
   endtask

   task automatic test_async_reset;
      #1 reset = 1'b0;
      #1;
      n_cmp++;
      if ({clk_out, tick, load_err} !== 12'h000) begin
         n_bad++;
         $display("FAIL async_reset_immediate: got %h want 000", {clk_out, tick, load_err});
      end
      mode = '0;
      en = '1;
      @(negedge clk_in);
      n_cmp++;
      if ({clk_out, tick} !== 8'h00) begin
         n_bad++;
         $display("FAIL async_reset_hold: got %h want 00", {clk_out, tick});
      end
      reset = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk_in);
         n_cmp++;
         if (tick !== ((k % 4 == 0) ? 4'hF : 4'h0) || clk_out !== (((k / 4) % 2 == 1) ? 4'hF : 4'h0)) begin
            n_bad++;
            $display("FAIL post_reset k=%0d: got tick=%h clk=%h", k, tick, clk_out);
         end
      end
   endtask

   initial begin
      test_reset;
      test_pulse_load;
      test_load_err;
      test_sync_clr;
      test_disable;
      test_async_reset;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
